// File: rtl/pushable_object_ctrl.sv
// Pushable/pullable object controller: fixed-point position, push/pull move rules,
// wall backoff with a frame-counted hold, and screen clamping.
module pushable_object_ctrl #(
    parameter int FRAC_BITS   = 6,
    parameter int SPEED       = 128,
    parameter int OBJ_W       = 32,
    parameter int OBJ_H       = 32,
    parameter int ACTOR_W     = 16,
    parameter int ACTOR_H     = 16,
    parameter int REACH       = 16,
    parameter int TOL         = 3,
    parameter int HOLD_FRAMES = 4,
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_start,
    input  logic               load,
    input  logic [10:0]        init_x,
    input  logic [10:0]        init_y,
    input  logic [10:0]        actor_x,
    input  logic [10:0]        actor_y,
    input  logic               key_u,
    input  logic               key_d,
    input  logic               key_l,
    input  logic               key_r,
    input  logic               magnet_on,
    input  logic               actor_touch,
    input  logic               wall_hit,
    input  logic [3:0]         hit_edge,
    output logic signed [10:0] obj_x,
    output logic signed [10:0] obj_y,
    output logic               moving,
    output logic [1:0]         dir,
    output logic               attached,
    output logic               blocked
);

    localparam int PW = 12 + FRAC_BITS;
    localparam int HW = (HOLD_FRAMES < 1) ? 1 : $clog2(HOLD_FRAMES + 1);

    localparam logic signed [PW-1:0] STEP  = PW'(SPEED);
    localparam logic signed [PW-1:0] MAX_X = PW'(SCREEN_W - OBJ_W);
    localparam logic signed [PW-1:0] MAX_Y = PW'(SCREEN_H - OBJ_H);

    localparam logic signed [11:0] LEFT_MIN  = 12'(-(ACTOR_W + REACH));
    localparam logic signed [11:0] RIGHT_MAX = 12'(OBJ_W + REACH);
    localparam logic signed [11:0] ABOVE_MIN = 12'(-(ACTOR_H + REACH));
    localparam logic signed [11:0] BELOW_MAX = 12'(OBJ_H + REACH);
    localparam logic signed [11:0] ALN_MIN   = 12'(-TOL);
    localparam logic signed [11:0] ALNX_MAX  = 12'(OBJ_W - ACTOR_W + TOL);
    localparam logic signed [11:0] ALNY_MAX  = 12'(OBJ_H - ACTOR_H + TOL);

    typedef enum logic [1:0] {FREE = 2'd0, ATTACHED = 2'd1, BLOCKED = 2'd2} state_t;
    typedef enum logic [1:0] {D_UP = 2'd0, D_DOWN = 2'd1, D_LEFT = 2'd2, D_RIGHT = 2'd3} dir_t;

    state_t                r_state, r_prev, w_state_nx, w_prev_nx, w_rules;
    dir_t                  r_dir, w_dir_nx, w_req_dir;
    logic signed [PW-1:0]  r_pos_x, r_pos_y, w_pos_x_nx, w_pos_y_nx, w_step_x, w_step_y;
    logic [HW-1:0]         r_hold, w_hold_nx;
    logic                  r_moving, w_moving_nx;
    logic signed [11:0]    w_dx, w_dy;
    logic                  w_left, w_right, w_above, w_below, w_algn_x, w_algn_y;
    logic                  w_one_key, w_zone_ok, w_aligned, w_move_ok;

    // A negative fixed-point value always has a negative integer part.
    function automatic logic signed [PW-1:0] f_clamp(input logic signed [PW-1:0] p,
                                                     input logic signed [PW-1:0] lim);
        if (p < 0)
            return '0;
        if ((p >>> FRAC_BITS) > lim)
            return lim <<< FRAC_BITS;
        return p;
    endfunction

    assign obj_x    = r_pos_x[FRAC_BITS +: 11];
    assign obj_y    = r_pos_y[FRAC_BITS +: 11];
    assign moving   = r_moving;
    assign dir      = r_dir;
    assign attached = (r_state == ATTACHED);
    assign blocked  = (r_state == BLOCKED);

    assign w_dx = {1'b0, actor_x} - {obj_x[10], obj_x};
    assign w_dy = {1'b0, actor_y} - {obj_y[10], obj_y};

    assign w_left   = (w_dx >= LEFT_MIN) && (w_dx < 12'sd0);
    assign w_right  = (w_dx > 12'sd0) && (w_dx <= RIGHT_MAX);
    assign w_above  = (w_dy >= ABOVE_MIN) && (w_dy < 12'sd0);
    assign w_below  = (w_dy > 12'sd0) && (w_dy <= BELOW_MAX);
    assign w_algn_x = (w_dx >= ALN_MIN) && (w_dx <= ALNX_MAX);
    assign w_algn_y = (w_dy >= ALN_MIN) && (w_dy <= ALNY_MAX);

    assign w_one_key = $onehot({key_u, key_d, key_l, key_r});
    assign w_rules   = (r_state == BLOCKED) ? r_prev : r_state;

    always_comb begin
        w_req_dir = D_UP;
        if (key_r)      w_req_dir = D_RIGHT;
        else if (key_l) w_req_dir = D_LEFT;
        else if (key_d) w_req_dir = D_DOWN;

        w_aligned = (w_req_dir == D_LEFT || w_req_dir == D_RIGHT) ? w_algn_y : w_algn_x;

        // Push needs the actor on the far side; pull needs it on the near side.
        w_zone_ok = 1'b0;
        if (w_rules == ATTACHED) begin
            case (w_req_dir)
                D_RIGHT: w_zone_ok = w_right;
                D_LEFT:  w_zone_ok = w_left;
                D_DOWN:  w_zone_ok = w_below;
                default: w_zone_ok = w_above;
            endcase
        end else begin
            case (w_req_dir)
                D_RIGHT: w_zone_ok = w_left;
                D_LEFT:  w_zone_ok = w_right;
                D_DOWN:  w_zone_ok = w_above;
                default: w_zone_ok = w_below;
            endcase
        end

        w_move_ok = w_one_key && w_aligned && w_zone_ok &&
                    !((r_state == BLOCKED) && (w_req_dir == r_dir));
    end

    always_comb begin
        w_state_nx  = r_state;
        w_prev_nx   = r_prev;
        w_hold_nx   = r_hold;
        w_moving_nx = r_moving;
        w_dir_nx    = r_dir;
        w_step_x    = '0;
        w_step_y    = '0;
        w_pos_x_nx  = r_pos_x;
        w_pos_y_nx  = r_pos_y;

        if (load) begin
            w_pos_x_nx  = f_clamp({1'b0, init_x, {FRAC_BITS{1'b0}}}, MAX_X);
            w_pos_y_nx  = f_clamp({1'b0, init_y, {FRAC_BITS{1'b0}}}, MAX_Y);
            w_state_nx  = FREE;
            w_prev_nx   = FREE;
            w_hold_nx   = '0;
            w_moving_nx = 1'b0;
        end else begin
            if (wall_hit) begin
                w_state_nx = BLOCKED;
                if (r_state != BLOCKED)
                    w_prev_nx = r_state;
                w_hold_nx = HW'(HOLD_FRAMES);
                // Back off only for a single edge on one axis.
                if (!(hit_edge[1] | hit_edge[3]) && (hit_edge[0] ^ hit_edge[2])) begin
                    w_step_y    = hit_edge[0] ? -STEP : STEP;
                    w_moving_nx = 1'b1;
                end else if (!(hit_edge[0] | hit_edge[2]) && (hit_edge[1] ^ hit_edge[3])) begin
                    w_step_x    = hit_edge[1] ? -STEP : STEP;
                    w_moving_nx = 1'b1;
                end
            end else begin
                if (frame_start) begin
                    w_moving_nx = w_move_ok;
                    if (w_move_ok) begin
                        w_dir_nx = w_req_dir;
                        case (w_req_dir)
                            D_UP:    w_step_y = -STEP;
                            D_DOWN:  w_step_y = STEP;
                            D_LEFT:  w_step_x = -STEP;
                            default: w_step_x = STEP;
                        endcase
                    end
                end
                case (r_state)
                    FREE:     if (magnet_on && actor_touch) w_state_nx = ATTACHED;
                    ATTACHED: if (!magnet_on) w_state_nx = FREE;
                    BLOCKED: begin
                        if (r_hold == '0)
                            w_state_nx = (r_prev == ATTACHED && magnet_on) ? ATTACHED : FREE;
                        else if (frame_start)
                            w_hold_nx = r_hold - 1'b1;
                    end
                    default:  w_state_nx = FREE;
                endcase
            end
            w_pos_x_nx = f_clamp(r_pos_x + w_step_x, MAX_X);
            w_pos_y_nx = f_clamp(r_pos_y + w_step_y, MAX_Y);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pos_x  <= {1'b0, init_x, {FRAC_BITS{1'b0}}};
            r_pos_y  <= {1'b0, init_y, {FRAC_BITS{1'b0}}};
            r_state  <= FREE;
            r_prev   <= FREE;
            r_hold   <= '0;
            r_moving <= 1'b0;
            r_dir    <= D_UP;
        end else begin
            r_pos_x  <= w_pos_x_nx;
            r_pos_y  <= w_pos_y_nx;
            r_state  <= w_state_nx;
            r_prev   <= w_prev_nx;
            r_hold   <= w_hold_nx;
            r_moving <= w_moving_nx;
            r_dir    <= w_dir_nx;
        end
    end

endmodule

// File: tb/tb_pushable_object_ctrl.sv
// Bench for pushable_object_ctrl: directed scenarios plus randomized traffic
// checked cycle-by-cycle against an integer reference model.
module tb_pushable_object_ctrl;

    localparam int FB    = 6;
    localparam int SPD   = 128;
    localparam int HOLD  = 4;
    localparam int OW    = 32;
    localparam int OH    = 32;
    localparam int AW    = 16;
    localparam int AH    = 16;
    localparam int RCH   = 16;
    localparam int TL    = 3;
    localparam int XMAX  = 640 - OW;
    localparam int YMAX  = 480 - OH;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset, frame_start, load;
    logic [10:0]        init_x, init_y, actor_x, actor_y;
    logic               key_u, key_d, key_l, key_r;
    logic               magnet_on, actor_touch, wall_hit;
    logic [3:0]         hit_edge;
    logic signed [10:0] obj_x, obj_y;
    logic               moving, attached, blocked;
    logic [1:0]         dir;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: positions in fixed-point ints; state 0=free 1=attached 2=blocked.
    int m_x, m_y, m_st, m_prev, m_hold, m_mov, m_dir;

    pushable_object_ctrl #(
        .FRAC_BITS(FB), .SPEED(SPD), .OBJ_W(OW), .OBJ_H(OH), .ACTOR_W(AW), .ACTOR_H(AH),
        .REACH(RCH), .TOL(TL), .HOLD_FRAMES(HOLD), .SCREEN_W(640), .SCREEN_H(480)
    ) dut (
        .clk(clk), .reset(reset), .frame_start(frame_start), .load(load),
        .init_x(init_x), .init_y(init_y), .actor_x(actor_x), .actor_y(actor_y),
        .key_u(key_u), .key_d(key_d), .key_l(key_l), .key_r(key_r),
        .magnet_on(magnet_on), .actor_touch(actor_touch), .wall_hit(wall_hit),
        .hit_edge(hit_edge), .obj_x(obj_x), .obj_y(obj_y), .moving(moving),
        .dir(dir), .attached(attached), .blocked(blocked)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int clampv(input int v, input int maxpx);
        if (v < 0) return 0;
        if ((v >>> FB) > maxpx) return maxpx * (1 << FB);
        return v;
    endfunction

    task automatic model_step();
        int ox, oy, dx, dy, nk, rd, rules;
        bit zone, aln, ok;
        if (reset) begin
            m_x = int'(init_x) * (1 << FB); m_y = int'(init_y) * (1 << FB);
            m_st = 0; m_prev = 0; m_hold = 0; m_mov = 0; m_dir = 0;
            return;
        end
        if (load) begin
            m_x = clampv(int'(init_x) * (1 << FB), XMAX);
            m_y = clampv(int'(init_y) * (1 << FB), YMAX);
            m_st = 0; m_prev = 0; m_hold = 0; m_mov = 0;
            return;
        end
        if (wall_hit) begin
            if (m_st != 2) m_prev = m_st;
            m_st = 2; m_hold = HOLD;
            if (hit_edge == 4'b0001)      begin m_y -= SPD; m_mov = 1; end
            else if (hit_edge == 4'b0100) begin m_y += SPD; m_mov = 1; end
            else if (hit_edge == 4'b0010) begin m_x -= SPD; m_mov = 1; end
            else if (hit_edge == 4'b1000) begin m_x += SPD; m_mov = 1; end
            m_x = clampv(m_x, XMAX); m_y = clampv(m_y, YMAX);
            return;
        end
        if (frame_start) begin
            ox = m_x >>> FB; oy = m_y >>> FB;
            dx = int'(actor_x) - ox; dy = int'(actor_y) - oy;
            nk = int'(key_u) + int'(key_d) + int'(key_l) + int'(key_r);
            rd = key_r ? 3 : key_l ? 2 : key_d ? 1 : 0;
            rules = (m_st == 2) ? m_prev : m_st;
            aln = (rd >= 2) ? (dy >= -TL && dy <= OH - AH + TL) : (dx >= -TL && dx <= OW - AW + TL);
            case (rd)
                3: zone = (rules == 1) ? (dx > 0 && dx <= OW + RCH) : (dx < 0 && dx >= -(AW + RCH));
                2: zone = (rules == 1) ? (dx < 0 && dx >= -(AW + RCH)) : (dx > 0 && dx <= OW + RCH);
                1: zone = (rules == 1) ? (dy > 0 && dy <= OH + RCH) : (dy < 0 && dy >= -(AH + RCH));
                default: zone = (rules == 1) ? (dy < 0 && dy >= -(AH + RCH)) : (dy > 0 && dy <= OH + RCH);
            endcase
            ok = (nk == 1) && aln && zone && !(m_st == 2 && rd == m_dir);
            if (ok) begin
                case (rd)
                    0: m_y -= SPD;
                    1: m_y += SPD;
                    2: m_x -= SPD;
                    default: m_x += SPD;
                endcase
                m_dir = rd; m_mov = 1;
                m_x = clampv(m_x, XMAX); m_y = clampv(m_y, YMAX);
            end else begin
                m_mov = 0;
            end
        end
        if (m_st == 0 && magnet_on && actor_touch) m_st = 1;
        else if (m_st == 1 && !magnet_on) m_st = 0;
        else if (m_st == 2) begin
            if (m_hold == 0) m_st = (m_prev == 1 && magnet_on) ? 1 : 0;
            else if (frame_start) m_hold--;
        end
    endtask

    task automatic compare_model();
        check("m_obj_x", int'(obj_x), m_x >>> FB);
        check("m_obj_y", int'(obj_y), m_y >>> FB);
        check("m_moving", int'(moving), m_mov);
        check("m_dir", int'(dir), m_dir);
        check("m_attached", int'(attached), int'(m_st == 1));
        check("m_blocked", int'(blocked), int'(m_st == 2));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    initial begin
        reset = 1'b1; frame_start = 1'b0; load = 1'b0;
        init_x = 11'd100; init_y = 11'd200; actor_x = '0; actor_y = '0;
        key_u = 1'b0; key_d = 1'b0; key_l = 1'b0; key_r = 1'b0;
        magnet_on = 1'b0; actor_touch = 1'b0; wall_hit = 1'b0; hit_edge = '0;
        tick();
        reset = 1'b0;
        check("rst_x", int'(obj_x), 100);
        check("rst_y", int'(obj_y), 200);
        check("rst_attached", int'(attached), 0);
        check("rst_blocked", int'(blocked), 0);
        check("rst_moving", int'(moving), 0);

        // Push right three frames
        actor_x = 11'd80; actor_y = 11'd205; key_r = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            frame();
            check("push_x", int'(obj_x), 100 + 2 * i);
            idle(2);
        end
        check("push_dir", int'(dir), 3);
        check("push_moving", int'(moving), 1);

        // Right-edge wall hit, then four suppressed frames
        wall_hit = 1'b1; hit_edge = 4'b0010;
        tick();
        wall_hit = 1'b0; hit_edge = '0;
        check("wall_x", int'(obj_x), 104);
        check("wall_blocked", int'(blocked), 1);
        for (int i = 1; i <= 4; i++) begin
            frame();
            check("hold_x", int'(obj_x), 104);
            idle(2);
        end
        frame();
        check("release_x", int'(obj_x), 106);
        check("release_blocked", int'(blocked), 0);
        check("release_attached", int'(attached), 0);

        // Pull mode
        key_r = 1'b0; init_x = 11'd100; init_y = 11'd200; load = 1'b1;
        tick();
        load = 1'b0;
        actor_x = 11'd136; actor_y = 11'd200; magnet_on = 1'b1; actor_touch = 1'b1;
        tick();
        actor_touch = 1'b0;
        check("attach", int'(attached), 1);
        key_r = 1'b1;
        for (int i = 1; i <= 2; i++) begin
            frame();
            check("pull_x", int'(obj_x), 100 + 2 * i);
            idle(2);
        end
        key_r = 1'b0; magnet_on = 1'b0;
        tick();
        check("detach", int'(attached), 0);

        // Clamp at the left edge, then an opposed-edge wall hit
        init_x = 11'd1; init_y = 11'd200; load = 1'b1;
        tick();
        load = 1'b0;
        actor_x = 11'd21; actor_y = 11'd205; key_l = 1'b1;
        frame();
        key_l = 1'b0;
        check("clamp_x", int'(obj_x), 0);
        wall_hit = 1'b1; hit_edge = 4'b0101;
        tick();
        wall_hit = 1'b0; hit_edge = '0;
        check("opp_edge_x", int'(obj_x), 0);
        check("opp_edge_y", int'(obj_y), 200);

        // Load in the middle of a hold
        frame(); idle(2); frame(); idle(1);
        check("mid_hold_blocked", int'(blocked), 1);
        init_x = 11'd300; init_y = 11'd300; load = 1'b1;
        tick();
        load = 1'b0;
        check("load_x", int'(obj_x), 300);
        check("load_y", int'(obj_y), 300);
        check("load_blocked", int'(blocked), 0);
        check("load_moving", int'(moving), 0);

        // Load beats a same-cycle frame move
        actor_x = 11'd280; actor_y = 11'd305; key_r = 1'b1;
        init_x = 11'd50; init_y = 11'd60; load = 1'b1; frame_start = 1'b1;
        tick();
        load = 1'b0; frame_start = 1'b0; key_r = 1'b0;
        check("load_win_x", int'(obj_x), 50);
        check("load_win_y", int'(obj_y), 60);
        check("load_win_moving", int'(moving), 0);

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            int ax, ay, k;
            reset       = ($urandom_range(0, 399) == 0);
            load        = ($urandom_range(0, 59) == 0);
            wall_hit    = ($urandom_range(0, 24) == 0);
            hit_edge    = 4'($urandom_range(0, 15));
            frame_start = ($urandom_range(0, 3) == 0);
            actor_touch = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 19) == 0) magnet_on = ~magnet_on;
            init_x = 11'($urandom_range(0, XMAX));
            init_y = 11'($urandom_range(0, YMAX));
            ax = (m_x >>> FB) + int'($urandom_range(0, 110)) - 50;
            ay = (m_y >>> FB) + int'($urandom_range(0, 110)) - 50;
            actor_x = 11'((ax < 0) ? 0 : ax);
            actor_y = 11'((ay < 0) ? 0 : ay);
            k = int'($urandom_range(0, 9));
            key_u = (k == 1) || (k == 5);
            key_d = (k == 2);
            key_l = (k == 3) || (k == 5);
            key_r = (k == 4) || (k == 6) || (k == 7);
            if (k == 8) begin key_r = 1'b1; key_d = 1'b1; end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pushable_object_ctrl.md
PUSHABLE_OBJECT_CTRL -- requirements
Module: pushable_object_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
  FRAC_BITS, 6, fixed-point fraction bits;
  SPEED, 128, step per frame in fixed-point units (2 px);
  OBJ_W / OBJ_H, 32 / 32, object size in px;
  ACTOR_W / ACTOR_H, 16 / 16, actor size in px;
  REACH, 16, max actor gap in px;
  TOL, 3, alignment tolerance in px;
  HOLD_FRAMES, 4, frames of move suppression after a wall hit;
  SCREEN_W / SCREEN_H, 640 / 480, screen size in px.
REQ-002 Ports SHALL be (name, direction, width, meaning):
  clk, in, 1, the single clock; rising edge only;
  reset, in, 1, synchronous, active-high;
  frame_start, in, 1, one-cycle pulse per frame;
  load, in, 1, respawn pulse;
  init_x / init_y, in, 11, respawn position in px (unsigned);
  actor_x / actor_y, in, 11, actor top-left in px (unsigned);
  key_u / key_d / key_l / key_r, in, 1, movement keys;
  magnet_on, in, 1, selects pull mode;
  actor_touch, in, 1, actor-object overlap strobe;
  wall_hit, in, 1, object-wall overlap strobe;
  hit_edge, in, 4, wall edge: [0]=below, [1]=right, [2]=above, [3]=left;
  obj_x / obj_y, out, 11 signed, object top-left in px;
  moving, out, 1, object moved on the last frame;
  dir, out, 2, last move direction: 0=up, 1=down, 2=left, 3=right;
  attached, out, 1, state is ATTACHED;
  blocked, out, 1, state is BLOCKED.
REQ-003 The block SHALL have one clock (clk) and a synchronous, active-high reset (reset). There SHALL be no other clock and no asynchronous logic.

Function
REQ-004 Position SHALL be held in signed fixed-point registers pos_x/pos_y, each 12+FRAC_BITS bits wide.
REQ-005 obj_x/obj_y SHALL equal pos >> FRAC_BITS (arithmetic shift), taken directly from the registers.
REQ-006 Offsets SHALL be computed as dx = actor_x - obj_x and dy = actor_y - obj_y, both signed 12-bit, in px.
REQ-007 Zones SHALL be defined as:
  - left: -(ACTOR_W+REACH) <= dx < 0;
  - right: 0 < dx <= OBJ_W+REACH;
  - above: -(ACTOR_H+REACH) <= dy < 0;
  - below: 0 < dy <= OBJ_H+REACH;
  - alignedY: -TOL <= dy <= OBJ_H-ACTOR_H+TOL;
  - alignedX: the same bounds applied to dx with OBJ_W/ACTOR_W.
REQ-008 A move request SHALL require exactly one key asserted. Zero keys or two or more keys SHALL produce no move.
REQ-009 The state machine SHALL have three states, FREE, ATTACHED and BLOCKED, encoded in 2 bits.
REQ-010 In FREE (push mode), the move rules SHALL be:
  - key_r with alignedY and left zone: +x;
  - key_l with alignedY and right zone: -x;
  - key_d with alignedX and above zone: +y;
  - key_u with alignedX and below zone: -y.
REQ-011 In ATTACHED (pull mode), the move rules SHALL be:
  - key_r with right zone: +x;
  - key_l with left zone: -x;
  - key_d with below zone: +y;
  - key_u with above zone: -y.
  Pull mode applies the same alignment requirement as REQ-010.
REQ-012 A move SHALL change the position by exactly SPEED on the cycle after frame_start and by nothing at any other time. Latency from frame_start to obj_x/obj_y change SHALL be 1 cycle.
REQ-013 FREE SHALL go to ATTACHED when magnet_on and actor_touch are both high in the same cycle.
REQ-014 ATTACHED SHALL go to FREE on the first cycle magnet_on is low.
REQ-015 A wall_hit SHALL move the object back by SPEED on every cycle it is high, as follows:
  - hit_edge[0] without [1] or [3]: -y;
  - hit_edge[2] without [1] or [3]: +y;
  - hit_edge[1] without [0] or [2]: -x;
  - hit_edge[3] without [0] or [2]: +x.
  Any other combination SHALL cause no backoff.
REQ-016 A wall_hit SHALL enter BLOCKED from any state and load the hold counter with HOLD_FRAMES. A wall_hit while already in BLOCKED SHALL reload the counter.
REQ-017 In BLOCKED, moves in direction dir SHALL be suppressed. Moves in other directions SHALL be allowed under the rules of the state held before the wall hit.
REQ-018 In BLOCKED, the hold counter SHALL decrement on each frame_start that occurs while wall_hit is low.
REQ-019 When the hold counter reaches 0, BLOCKED SHALL exit to ATTACHED if the pre-hit state was ATTACHED and magnet_on is high, and to FREE otherwise.
REQ-020 After every update, the integer position SHALL be clamped to x in [0, SCREEN_W-OBJ_W] and y in [0, SCREEN_H-OBJ_H]. When clamped, the fraction bits SHALL be cleared.
REQ-021 moving SHALL be set on a frame in which a move or backoff occurred, and cleared on the next frame_start that produces no move. dir SHALL update only on frame moves.
REQ-022 Same-cycle priority SHALL be reset > load > wall_hit backoff > frame move.
REQ-023 load SHALL set the position to init_x/init_y with zero fraction, go to FREE, clear the counter, and clear moving. This SHALL apply in any state, including mid-BLOCKED.

Reset
REQ-024 On reset:
  - position SHALL be set to init_x/init_y;
  - state SHALL be FREE and the hold counter 0;
  - moving, attached and blocked SHALL be 0;
  - dir SHALL be 0.
REQ-025 Inputs SHALL be ignored during the reset cycle.

Verification
REQ-026 Defaults apply to all scenarios. The bench SHALL cover:
  - Reset with init (100,200): obj (100,200); FREE; moving=0.
  - Actor (80,205), key_r held, 3 frame_start pulses: obj_x 102, 104, 106, each 1 cycle after its pulse; dir=3; moving=1.
  - Starting from obj_x=106, wall_hit with hit_edge=4'b0010 for 1 cycle: obj_x=104; blocked=1; key_r ignored for 4 frames; on frame 5, obj_x=106 and state FREE.
  - Actor (136,200), magnet_on and actor_touch high: attached=1. key_r for 2 frames: obj_x 100 to 104. Drop magnet_on: FREE the next cycle.
  - Object at (1,200), left push for 1 frame: obj_x=0, not -1. hit_edge=4'b0101 with wall_hit: no position change.
  - load with init (300,300) while BLOCKED with counter 2: obj (300,300); FREE; counter 0. A load and a frame move in the same cycle: the load wins.
